alu_mul_sequencer: RTL

- Multi-cycle unsigned multiplier that drives the 16-bit ALU as its initiator. Each cycle it issues operands, FunSel and WF, then consumes ALUOut and the registered flags.
- Implements shift-and-add: the multiplier is shifted right through the ALU and the resulting carry flag decides whether to add.
- Sits between the control unit (Start/Done handshake) and the ALU port. It owns the ALU while Busy=1.

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/alu_mul_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-select codes, flag bit positions and the
// multiply sequencer state encoding.
package alu_pkg;

   // 8-bit operations (upper FunSel bit clear)
   localparam logic [4:0] A_8          = 5'b00000;
   localparam logic [4:0] B_8          = 5'b00001;
   localparam logic [4:0] NOT_A_8      = 5'b00010;
   localparam logic [4:0] NOT_B_8      = 5'b00011;
   localparam logic [4:0] A_PLUS_B_8   = 5'b00100;
   localparam logic [4:0] A_PLUS_B_C_8 = 5'b00101;
   localparam logic [4:0] A_MINUS_B_8  = 5'b00110;
   localparam logic [4:0] A_AND_B_8    = 5'b00111;
   localparam logic [4:0] A_OR_B_8     = 5'b01000;
   localparam logic [4:0] A_XOR_B_8    = 5'b01001;
   localparam logic [4:0] A_NAND_B_8   = 5'b01010;
   localparam logic [4:0] LSL_A_8      = 5'b01011;
   localparam logic [4:0] LSR_A_8      = 5'b01100;
   localparam logic [4:0] ASR_A_8      = 5'b01101;
   localparam logic [4:0] CSL_A_8      = 5'b01110;
   localparam logic [4:0] CSR_A_8      = 5'b01111;

   // 16-bit operations (upper FunSel bit set)
   localparam logic [4:0] A_16          = 5'b10000;
   localparam logic [4:0] B_16          = 5'b10001;
   localparam logic [4:0] NOT_A_16      = 5'b10010;
   localparam logic [4:0] NOT_B_16      = 5'b10011;
   localparam logic [4:0] A_PLUS_B_16   = 5'b10100;
   localparam logic [4:0] A_PLUS_B_C_16 = 5'b10101;
   localparam logic [4:0] A_MINUS_B_16  = 5'b10110;
   localparam logic [4:0] A_AND_B_16    = 5'b10111;
   localparam logic [4:0] A_OR_B_16     = 5'b11000;
   localparam logic [4:0] A_XOR_B_16    = 5'b11001;
   localparam logic [4:0] A_NAND_B_16   = 5'b11010;
   localparam logic [4:0] LSL_A_16      = 5'b11011;
   localparam logic [4:0] LSR_A_16      = 5'b11100;
   localparam logic [4:0] ASR_A_16      = 5'b11101;
   localparam logic [4:0] CSL_A_16      = 5'b11110;
   localparam logic [4:0] CSR_A_16      = 5'b11111;

   // Flag bit positions within the {Z,C,N,O} flag word
   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_O = 0;

   // Shift-and-add multiply sequencer states
   typedef enum logic [2:0] {
      IDLE,
      SHR,
      TEST,
      ADD,
      SHL,
      DONE
   } mulState_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared 16-bit ALU for
// every arithmetic step. The multiplier is shifted right through the ALU; the
// carry flag it leaves behind decides whether the multiplicand is added, and
// the zero flag from the same shift ends the loop once no set bits remain.
module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter int OPW = 8
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_start,
   input  logic [OPW-1:0] i_multiplicand,
   input  logic [OPW-1:0] i_multiplier,
   output logic           o_busy,
   output logic           o_done,
   output logic [15:0]    o_product,
   output logic [15:0]    o_aluA,
   output logic [15:0]    o_aluB,
   output logic [4:0]     o_aluFunSel,
   output logic           o_aluWf,
   input  logic [15:0]    i_aluOut,
   input  logic [3:0]     i_flagsIn
);

   mulState_t   r_state;
   mulState_t   w_nextState;
   logic [15:0] r_mcand;
   logic [15:0] r_mplr;
   logic [15:0] r_acc;
   logic [15:0] r_product;
   logic        w_unusedFlags;

   // N and O are never consulted by the multiply loop
   assign w_unusedFlags = ^i_flagsIn[FLAG_N:FLAG_O];

   assign o_busy    = (r_state != IDLE);
   assign o_done    = (r_state == DONE);
   assign o_product = r_product;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decode and ALU drive; flags are only written during the shift
   // right, so Z seen in SHL is still the one produced by that shift
   always_comb begin
      w_nextState = r_state;
      o_aluA      = 16'h0000;
      o_aluB      = 16'h0000;
      o_aluFunSel = A_16;
      o_aluWf     = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_nextState = SHR;
            end
         end
         SHR: begin
            o_aluA      = r_mplr;
            o_aluFunSel = LSR_A_16;
            o_aluWf     = 1'b1;
            w_nextState = TEST;
         end
         TEST: begin
            w_nextState = i_flagsIn[FLAG_C] ? ADD : SHL;
         end
         ADD: begin
            o_aluA      = r_acc;
            o_aluB      = r_mcand;
            o_aluFunSel = A_PLUS_B_16;
            w_nextState = SHL;
         end
         SHL: begin
            o_aluA      = r_mcand;
            o_aluFunSel = LSL_A_16;
            w_nextState = i_flagsIn[FLAG_Z] ? DONE : SHR;
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath registers; the product is captured on the edge into DONE so it
   // is already valid while Done is high, and it then holds until the next
   // accepted request finishes
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mcand   <= 16'h0000;
         r_mplr    <= 16'h0000;
         r_acc     <= 16'h0000;
         r_product <= 16'h0000;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_mcand <= {{(16-OPW){1'b0}}, i_multiplicand};
                  r_mplr  <= {{(16-OPW){1'b0}}, i_multiplier};
                  r_acc   <= 16'h0000;
               end
            end
            SHR: begin
               r_mplr <= i_aluOut;
            end
            ADD: begin
               r_acc <= i_aluOut;
            end
            SHL: begin
               r_mcand <= i_aluOut;
               if (i_flagsIn[FLAG_Z]) begin
                  r_product <= r_acc;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
